// File: rtl/dp_mac_simd.sv
// dp_mac_simd: pipelined SIMD dot-product accumulator.
// Lanes are split at a runtime precision; the packet sum saturates to ACC_W.
module dp_mac_simd #(
    parameter int W     = 32,
    parameter int ACC_W = 72
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [2:0]       in_mode,
    input  logic             in_sgn,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
    localparam int NP = $clog2(W);
    localparam int PW = 2 * W + 2;

    localparam logic [ACC_W-1:0] UMAX = '1;
    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic                 stall;
    logic                 accept;
    logic                 first_q;
    logic                 sgn_q;
    logic [2:0]           mode_q;
    logic [2:0]           mode_c;
    logic [2:0]           mode_e;
    logic                 sgn_e;
    logic signed [PW-1:0] psum [NP];
    logic signed [PW-1:0] beat;

    logic                 s1_v;
    logic                 s1_last;
    logic                 s1_sgn;
    logic [ACC_W-1:0]     s1_p;

    logic [ACC_W-1:0]     acc_q;
    logic                 ovf_q;
    logic [ACC_W:0]       sum_x;
    logic [ACC_W-1:0]     sat;
    logic                 clamp;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & ~stall;

    // Out-of-range codes fall back to the narrowest legal lane (L = 2).
    assign mode_c = (int'(in_mode) > NP - 1) ? 3'(NP - 1) : in_mode;
    assign mode_e = first_q ? mode_c : mode_q;
    assign sgn_e  = first_q ? in_sgn : sgn_q;

    for (genvar p = 0; p < NP; p++) begin : g_mode
        localparam int L = W >> p;
        localparam int N = 1 << p;
        logic signed [L:0]     la;
        logic signed [L:0]     lb;
        logic signed [2*L+1:0] prod;
        logic signed [PW-1:0]  sum;
        always_comb begin
            sum  = '0;
            la   = '0;
            lb   = '0;
            prod = '0;
            for (int i = 0; i < N; i++) begin
                la   = {sgn_e & in_a[i*L+L-1], in_a[i*L +: L]};
                lb   = {sgn_e & in_b[i*L+L-1], in_b[i*L +: L]};
                prod = (2*L+2)'(la) * (2*L+2)'(lb);
                sum  = sum + PW'(prod);
            end
        end
        assign psum[p] = sum;
    end

    always_comb begin
        beat = '0;
        for (int p = 0; p < NP; p++) begin
            if (int'(mode_e) == p) beat = psum[p];
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s1_sgn  <= 1'b0;
            s1_p    <= '0;
            first_q <= 1'b1;
            mode_q  <= '0;
            sgn_q   <= 1'b0;
        end else if (!stall) begin
            s1_v    <= in_valid;
            s1_last <= in_last;
            s1_sgn  <= sgn_e;
            s1_p    <= ACC_W'(beat);
            if (accept) begin
                first_q <= in_last;
                if (first_q) begin
                    mode_q <= mode_c;
                    sgn_q  <= in_sgn;
                end
            end
        end
    end

    // One extra bit of headroom detects overflow before clamping.
    always_comb begin
        sum_x = '0;
        sat   = '0;
        clamp = 1'b0;
        if (s1_sgn) begin
            sum_x = {acc_q[ACC_W-1], acc_q} + {s1_p[ACC_W-1], s1_p};
            clamp = sum_x[ACC_W] ^ sum_x[ACC_W-1];
            if (clamp) sat = sum_x[ACC_W] ? SMIN : SMAX;
            else sat = sum_x[ACC_W-1:0];
        end else begin
            sum_x = {1'b0, acc_q} + {1'b0, s1_p};
            clamp = sum_x[ACC_W];
            sat   = clamp ? UMAX : sum_x[ACC_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1_v & s1_last;
            if (s1_v) begin
                if (s1_last) begin
                    out_acc <= sat;
                    out_ovf <= ovf_q | clamp;
                    acc_q   <= '0;
                    ovf_q   <= 1'b0;
                end else begin
                    acc_q <= sat;
                    ovf_q <= ovf_q | clamp;
                end
            end
        end
    end
endmodule

// File: tb/tb_dp_mac_simd.sv
// tb_dp_mac_simd: scoreboard bench for dp_mac_simd.
// Instance 0 uses ACC_W=72, instance 1 uses ACC_W=64 for saturation.
module tb_dp_mac_simd;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    int          vsel = 0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_mode = '0;
    logic        in_sgn = 1'b0;
    logic        in_last = 1'b0;
    int          rdy_mode = 0;
    logic [1:0]  rnd = '0;

    logic        in_valid0, in_ready0, out_valid0, out_ready0, out_ovf0;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, out_ovf1;
    logic [71:0] out_acc0;
    logic [63:0] out_acc1;

    int n_tests = 0;
    int n_fail  = 0;

    assign in_valid0  = in_valid & (vsel == 0);
    assign in_valid1  = in_valid & (vsel == 1);
    assign out_ready0 = (rdy_mode == 0) | ((rdy_mode == 1) & rnd[0]);
    assign out_ready1 = (rdy_mode == 0) | ((rdy_mode == 1) & rnd[1]);

    always @(posedge clk) begin
        #1;
        rnd = 2'($urandom);
    end

    dp_mac_simd #(.W(32), .ACC_W(72)) dut0 (
        .CLK(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .in_sgn(in_sgn), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_acc(out_acc0), .out_ovf(out_ovf0)
    );

    dp_mac_simd #(.W(32), .ACC_W(64)) dut1 (
        .CLK(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .in_sgn(in_sgn), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_acc(out_acc1), .out_ovf(out_ovf1)
    );

    typedef struct packed {
        logic [71:0] acc;
        logic        ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    logic signed [159:0] m_acc   [2];
    logic                m_ovf   [2];
    logic                m_first [2];
    int                  m_mode  [2];
    logic                m_sgn   [2];

    task automatic chk(input string nm, input logic [71:0] got,
                       input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b required %0b", nm, got, exp);
        end
    endtask

    // Reference: exact lane-wise dot product from plain integer arithmetic.
    function automatic logic signed [159:0] beat_val(
        input logic [31:0] a, input logic [31:0] b,
        input int p, input logic sg);
        int                  ln;
        int                  n;
        logic signed [159:0] s;
        longint              x;
        longint              y;
        logic [63:0]         msk;
        ln  = 32 >> p;
        n   = 1 << p;
        s   = '0;
        msk = (64'd1 << ln) - 64'd1;
        for (int i = 0; i < n; i++) begin
            x = longint'(({32'd0, a} >> (i * ln)) & msk);
            y = longint'(({32'd0, b} >> (i * ln)) & msk);
            if (sg && x >= (longint'(1) << (ln - 1))) x = x - (longint'(1) << ln);
            if (sg && y >= (longint'(1) << (ln - 1))) y = y - (longint'(1) << ln);
            s = s + 160'(x) * 160'(y);
        end
        return s;
    endfunction

    task automatic reset_models();
        for (int s = 0; s < 2; s++) begin
            m_acc[s]   = '0;
            m_ovf[s]   = 1'b0;
            m_first[s] = 1'b1;
            m_mode[s]  = 0;
            m_sgn[s]   = 1'b0;
        end
    endtask

    task automatic model_accept(input int s, input logic [31:0] a,
                                input logic [31:0] b, input logic [2:0] m,
                                input logic sg, input logic lst);
        logic signed [159:0] hi, lo, t, one;
        int   aw;
        exp_t e;
        one = 1;
        aw  = (s == 0) ? 72 : 64;
        if (m_first[s]) begin
            m_mode[s] = (m > 3'd4) ? 4 : int'(m);
            m_sgn[s]  = sg;
        end
        t  = m_acc[s] + beat_val(a, b, m_mode[s], m_sgn[s]);
        hi = m_sgn[s] ? ((one <<< (aw - 1)) - 1) : ((one <<< aw) - 1);
        lo = m_sgn[s] ? -(one <<< (aw - 1)) : 160'sd0;
        if (t > hi) begin t = hi; m_ovf[s] = 1'b1; end
        if (t < lo) begin t = lo; m_ovf[s] = 1'b1; end
        m_acc[s]   = t;
        m_first[s] = lst;
        if (lst) begin
            e.acc = (s == 0) ? t[71:0] : {8'd0, t[63:0]};
            e.ovf = m_ovf[s];
            if (s == 0) q0.push_back(e);
            else q1.push_back(e);
            m_acc[s] = '0;
            m_ovf[s] = 1'b0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send_beat(input int s, input logic [31:0] a,
                             input logic [31:0] b, input logic [2:0] m,
                             input logic sg, input logic lst);
        bit ok;
        ok = 1'b0;
        vsel = s; in_a = a; in_b = b; in_mode = m;
        in_sgn = sg; in_last = lst; in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (s == 0) ? in_ready0 : in_ready1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            in_valid = 1'b0;
            $display("FAIL in_ready_timeout: in_ready 0 required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (ok) model_accept(s, a, b, m, sg, lst);
    endtask

    task automatic expect_out(input int s, input string nm,
                              input logic [71:0] ea, input logic eo);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if ((s == 0) ? out_valid0 : out_valid1) begin
                got = 1'b1;
                chk({nm, "_acc"}, (s == 0) ? out_acc0 : {8'd0, out_acc1}, ea);
                chk1({nm, "_ovf"}, (s == 0) ? out_ovf0 : out_ovf1, eo);
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: out_valid 0 required 1", nm);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 3))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8080_8080 ^ ($urandom & 32'h0F0F_0F0F);
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid0) begin
            if (q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out0_unexpected: got %0h required none", out_acc0);
            end else begin
                chk("out0_acc", out_acc0, q0[0].acc);
                chk1("out0_ovf", out_ovf0, q0[0].ovf);
                if (out_ready0) e0 = q0.pop_front();
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1) begin
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out1_unexpected: got %0h required none", out_acc1);
            end else begin
                chk("out1_acc", {8'd0, out_acc1}, q1[0].acc);
                chk1("out1_ovf", out_ovf1, q1[0].ovf);
                if (out_ready1) e1 = q1.pop_front();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int len;
        reset_models();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_valid0", out_valid0, 1'b0);
        chk("rst_acc0", out_acc0, 72'd0);
        chk1("rst_ovf0", out_ovf0, 1'b0);
        chk1("rst_ready0", in_ready0, 1'b1);
        chk1("rst_valid1", out_valid1, 1'b0);
        chk1("rst_ready1", in_ready1, 1'b1);
        @(posedge clk);
        #1;

        rdy_mode = 0;
        send_beat(0, 32'h2222_2222, 32'h2222_2222, 3'd2, 1'b0, 1'b1);
        @(negedge clk);
        chk1("lat_edge_k", out_valid0, 1'b0);
        @(negedge clk);
        chk1("lat_edge_k1", out_valid0, 1'b1);
        chk("int8_acc", out_acc0, 72'h1210);
        chk1("int8_ovf", out_ovf0, 1'b0);
        @(posedge clk);
        #1;

        send_beat(0, 32'h5555_5555, 32'h5555_5555, 3'd4, 1'b0, 1'b1);
        expect_out(0, "int2", 72'd16, 1'b0);
        send_beat(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b1, 1'b1);
        expect_out(0, "int16s", 72'd2, 1'b0);
        send_beat(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0, 1'b1);
        expect_out(0, "int16u", 72'h1_FFFC_0002, 1'b0);

        for (int k = 0; k < 3; k++)
            send_beat(0, '1, '1, 3'd0, 1'b0, k == 2);
        expect_out(0, "int32x3", 72'h2_FFFF_FFFA_0000_0003, 1'b0);
        send_beat(0, '1, '1, 3'd0, 1'b0, 1'b0);
        send_beat(0, '1, '1, 3'd4, 1'b1, 1'b0);
        send_beat(0, '1, '1, 3'd4, 1'b1, 1'b1);
        expect_out(0, "mode_latch", 72'h2_FFFF_FFFA_0000_0003, 1'b0);

        rdy_mode = 2;
        send_beat(0, 32'h2222_2222, 32'h2222_2222, 3'd2, 1'b0, 1'b1);
        send_beat(0, 32'h1111_1111, 32'h0101_0101, 3'd2, 1'b0, 1'b0);
        vsel = 0; in_a = 32'h0202_0202; in_b = 32'h0303_0303;
        in_mode = 3'd2; in_sgn = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk1("bp_in_ready", in_ready0, 1'b0);
            chk1("bp_hold_valid", out_valid0, 1'b1);
            chk("bp_hold_acc", out_acc0, 72'h1210);
            @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        @(negedge clk);
        chk1("bp_release_ready", in_ready0, 1'b1);
        @(posedge clk);
        #1;
        rdy_mode = 2;
        in_valid = 1'b0;
        model_accept(0, 32'h0202_0202, 32'h0303_0303, 3'd2, 1'b0, 1'b1);
        @(negedge clk);
        chk1("bp_gap_valid", out_valid0, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("bp_second_valid", out_valid0, 1'b1);
        chk("bp_second_acc", out_acc0, 72'h5C);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        send_beat(0, 32'h5555_5555, 32'h5555_5555, 3'd4, 1'b0, 1'b1);
        send_beat(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b1, 1'b1);
        @(negedge clk);
        chk1("b2b_c_valid", out_valid0, 1'b1);
        chk("b2b_c_acc", out_acc0, 72'd16);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("b2b_d_valid", out_valid0, 1'b1);
        chk("b2b_d_acc", out_acc0, 72'd2);
        @(posedge clk);
        #1;

        send_beat(1, '1, '1, 3'd0, 1'b0, 1'b0);
        send_beat(1, '1, '1, 3'd0, 1'b0, 1'b1);
        expect_out(1, "sat", 72'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        send_beat(1, 32'd1, 32'd1, 3'd0, 1'b0, 1'b1);
        expect_out(1, "post_sat", 72'd1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        send_beat(0, 32'h2222_2222, 32'h2222_2222, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_models();
        @(negedge clk);
        chk1("mid_rst_valid", out_valid0, 1'b0);
        chk1("mid_rst_ready", in_ready0, 1'b1);
        @(posedge clk);
        #1;
        send_beat(0, 32'h0101_0101, 32'h0101_0101, 3'd2, 1'b0, 1'b1);
        expect_out(0, "post_rst", 72'd4, 1'b0);

        rdy_mode = 1;
        for (int pk = 0; pk < 250; pk++) begin
            s   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            len = $urandom_range(1, 4);
            for (int bt = 0; bt < len; bt++)
                send_beat(s, rnd_op(), rnd_op(), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), bt == len - 1);
        end
        rdy_mode = 0;
        for (int i = 0; i < 50 && (q0.size() + q1.size()) != 0; i++)
            @(negedge clk);
        chk("drain", 72'(q0.size() + q1.size()), 72'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dp_mac_simd.md
# dp_mac_simd

Parametrised, pipelined SIMD dot-product accumulator, the streaming successor to the combinational 32-bit multi-precision dot-product unit. Each accepted beat splits two W-bit operands into equal lanes at a runtime-selected precision, forms the lane-wise dot product, and accumulates it across a multi-beat packet. Packets end on `in_last`. The saturated sum is presented on a valid/ready output port. It sits between the operand streamer and the result writeback.

## Interface
- `W`, default 32: operand width. Must be a power of two, 16..256.
- `ACC_W`, default 72: accumulator and result width. Must satisfy ACC_W ≥ 2W.
- `CLK` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: beat present.
- `in_ready` out 1: block can accept a beat.
- `in_a`, `in_b` in W: operands. Lane i occupies bits [(i+1)L-1 : iL].
- `in_mode` in 3: precision code p. Lane width L = W >> p.
- `in_sgn` in 1: 1 = two's-complement lanes, 0 = unsigned.
- `in_last` in 1: final beat of the packet.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer accepts.
- `out_acc` out ACC_W: packet dot-product sum.
- `out_ovf` out 1: saturation occurred during the packet.

## Operation
- Precision codes, W=32:
  - p=0: 1×int32
  - p=1: 2×int16
  - p=2: 4×int8
  - p=3: 8×int4
  - p=4: 16×int2
- Any p > log2(W)−1 is clamped to log2(W)−1, so L is never below 2.
- Lane product is a[i]·b[i], signed or unsigned per `in_sgn`. Beat value P is the sum of all W/L lane products, computed exactly.
  - Unsigned P is zero-extended to ACC_W.
  - Signed P is sign-extended to ACC_W.
- Mode/sign latching:
  - Mode and sign are latched on the first beat of a packet, meaning the first beat after reset or after a last beat.
  - `in_mode` and `in_sgn` on later beats of the same packet are ignored.
- Pipeline stages:
  - S1 registers P, `last`, the latched sign, and a valid bit.
  - S2 accumulator ACC adds the S1 value. The add is performed at ACC_W+1 bits, then saturated.
- Saturation:
  - Unsigned: results above 2^ACC_W−1 clamp to 2^ACC_W−1.
  - Signed: results clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Any clamp sets a sticky packet overflow flag OVF.
- When S1 holds a last beat:
  - `out_acc` ← sat(ACC+P) and `out_ovf` ← OVF | clamp_now.
  - `out_valid` ← 1.
  - ACC ← 0 and OVF ← 0.
- A single-beat packet yields `out_acc` = P.

## Timing
- Stall and ready:
  - stall = `out_valid` & ~`out_ready`.
  - `in_ready` = ~stall, combinational.
  - While stalled, S1, ACC, OVF and the output registers all hold. The hold applies even if S1 is not a last beat.
- Latency: a last beat accepted at edge k drives `out_valid`=1 after edge k+1 (2-cycle latency). Throughput is one beat per cycle when not stalled.
- `out_valid` clears on the edge where `out_valid` & `out_ready` are both 1, unless a new last beat completes on that same edge.
  - In that case `out_valid` stays 1 and `out_acc`/`out_ovf` update.
  - There is no bubble.
- While `out_valid`=1 and `out_ready`=0, `out_acc` and `out_ovf` are stable.
- Reset values after any edge with `rst`=1:
  - `out_valid`=0, `out_acc`=0, `out_ovf`=0.
  - S1 valid=0, ACC=0, OVF=0.
  - Next accepted beat is treated as a first beat.
  - `in_ready`=1 in the cycle after reset.
- Reset mid-packet discards the partial sum. No result is emitted for that packet.
- `rst` has priority over all simultaneous handshakes.

## Test plan
- **int8 unsigned:** W=32, p=2, sgn=0, `in_a`=`in_b`=0x22222222, single last beat → `out_acc`=0x1210 and `out_ovf`=0, `out_valid` rising 2 cycles after acceptance.
- **int2 and int16:**
  - p=4, unsigned, `in_a`=`in_b`=0x55555555 → 16.
  - p=1, signed, `in_a`=`in_b`=0xFFFFFFFF → 2.
  - p=1, unsigned, same operands → 0x1FFFC0002.
- **Multi-beat int32:** three back-to-back p=0 unsigned beats of 0xFFFFFFFF, last on the third → `out_acc`=0x2FFFFFFFA00000003. A mode change on beats 2–3 to p=4 is ignored, giving the same result.
- **Backpressure:** hold `out_ready`=0 with a result pending and stream the next packet → `in_ready`=0 and `out_acc` stable. Raise `out_ready` for one cycle → second result appears the next cycle with no lost or duplicated beats. Also check the same-edge accept + new-last case keeps `out_valid`=1.
- **Saturation:** ACC_W=64, p=0 unsigned, two beats of 0xFFFFFFFF → `out_acc`=0xFFFFFFFFFFFFFFFF, `out_ovf`=1. The next single-beat packet 1×1 → 1 with `out_ovf`=0.
- **Reset mid-packet:** assert `rst` after beat 1 of 2 → `out_valid`=0 and the new packet's sum excludes the pre-reset beats.
